pc_dispatch_fifo: RTL and testbench

// - Two-bank PC queue on both sides of basic_block: takes its output PCs, returns them as its input PCs.
// - Bank "cur" holds threads for the character being matched; bank "nxt" holds threads for the following character.
// - Routing follows output_pc_is_directed_to_current.
// - On character advance the banks swap roles; no data is copied.

---
 rtl/pc_dispatch_pkg.sv | 14 +
 rtl/pc_dispatch_fifo_if.sv | 53 +++++
 rtl/pc_bank_fifo.sv | 54 +++++
 rtl/pc_dispatch_fifo.sv | 107 ++++++++++
 tb/tb_pc_dispatch_fifo.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pc_dispatch_pkg.sv
// Shared types and helpers for the two-bank PC dispatch queue.
package pc_dispatch_pkg;

  // Routing role of a PC, encoded to match in_pc_is_directed_to_current.
  typedef enum logic {
    SEL_NXT = 1'b0,
    SEL_CUR = 1'b1
  } bank_sel_t;

  function automatic int depth_f(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/pc_dispatch_fifo_if.sv
// Handshake bundle between controller/basic_block and pc_dispatch_fifo.
// PC_DISPATCH_OCCUPANCY_EN adds cur_count, nxt_count and high_watermark.
interface pc_dispatch_fifo_if #(
  parameter int PC_WIDTH   = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                start_valid;
  logic [PC_WIDTH-1:0] start_pc;
  logic                start_ready;
  logic                in_pc_valid;
  logic [PC_WIDTH-1:0] in_pc;
  logic                in_pc_is_directed_to_current;
  logic                in_pc_ready;
  logic                out_pc_valid;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_pc_ready;
  logic                advance;
  logic                advance_done;
  logic                cur_empty;
  logic                nxt_empty;
  logic                overflow;
`ifdef PC_DISPATCH_OCCUPANCY_EN
  logic [DEPTH_LOG2:0] cur_count;
  logic [DEPTH_LOG2:0] nxt_count;
  logic [DEPTH_LOG2:0] high_watermark;

  modport master (
    output start_valid, start_pc, in_pc_valid, in_pc, in_pc_is_directed_to_current,
           out_pc_ready, advance,
    input  start_ready, in_pc_ready, out_pc_valid, out_pc, advance_done,
           cur_empty, nxt_empty, overflow, cur_count, nxt_count, high_watermark
  );
  modport slave (
    input  start_valid, start_pc, in_pc_valid, in_pc, in_pc_is_directed_to_current,
           out_pc_ready, advance,
    output start_ready, in_pc_ready, out_pc_valid, out_pc, advance_done,
           cur_empty, nxt_empty, overflow, cur_count, nxt_count, high_watermark
  );
`else
  modport master (
    output start_valid, start_pc, in_pc_valid, in_pc, in_pc_is_directed_to_current,
           out_pc_ready, advance,
    input  start_ready, in_pc_ready, out_pc_valid, out_pc, advance_done,
           cur_empty, nxt_empty, overflow
  );
  modport slave (
    input  start_valid, start_pc, in_pc_valid, in_pc, in_pc_is_directed_to_current,
           out_pc_ready, advance,
    output start_ready, in_pc_ready, out_pc_valid, out_pc, advance_done,
           cur_empty, nxt_empty, overflow
  );
`endif
endinterface

// File: rtl/pc_bank_fifo.sv
// One circular PC bank; push and pop may coincide, pop frees the slot first.
module pc_bank_fifo
  import pc_dispatch_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic [PC_WIDTH-1:0] i_data,
  input  logic                i_pop,
  output logic [PC_WIDTH-1:0] o_head,
  output logic [DEPTH_LOG2:0] o_count,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_ovf
);
  localparam int DEPTH = depth_f(DEPTH_LOG2);

  logic [PC_WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push, w_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // A push the top level should never have issued; surfaced as sticky overflow.
  assign o_ovf   = i_push && o_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pc_dispatch_fifo.sv
// Two-bank PC queue around basic_block: routes PCs to cur/nxt banks and swaps roles on advance.
// PC_DISPATCH_OCCUPANCY_EN exposes per-bank counts and a high watermark.
module pc_dispatch_fifo
  import pc_dispatch_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  pc_dispatch_fifo_if.slave  bus
);
  logic                          r_cur_sel;
  logic                          r_adv_done;
  logic                          r_ovf;

  logic [1:0][PC_WIDTH-1:0]      w_head, w_wdata;
  logic [1:0][DEPTH_LOG2:0]      w_count;
  logic [1:0]                    w_push, w_pop_b, w_full, w_empty, w_ovf, w_is_cur;

  bank_sel_t                     w_dir;
  logic [DEPTH_LOG2:0]           w_cur_count;
  logic                          w_out_vld, w_pop, w_cur_room, w_nxt_full;
  logic                          w_in_rdy, w_start_rdy, w_in_fire, w_start_fire;
  logic                          w_cur_push, w_nxt_push, w_adv_ok;
  logic [PC_WIDTH-1:0]           w_cur_wdata;

  assign w_dir       = bank_sel_t'(bus.in_pc_is_directed_to_current);
  assign w_cur_count = w_count[r_cur_sel];
  assign w_nxt_full  = w_full[~r_cur_sel];
  assign w_out_vld   = (w_cur_count != '0);
  assign w_pop       = w_out_vld && bus.out_pc_ready;
  // A concurrent pop frees a slot in a full cur bank for the same-cycle push.
  assign w_cur_room  = !w_full[r_cur_sel] || w_pop;

  assign w_in_rdy    = !bus.in_pc_valid || ((w_dir == SEL_CUR) ? w_cur_room : !w_nxt_full);
  assign w_start_rdy = !w_full[r_cur_sel] && !(bus.in_pc_valid && (w_dir == SEL_CUR));
  assign w_in_fire    = bus.in_pc_valid && w_in_rdy;
  assign w_start_fire = bus.start_valid && w_start_rdy;
  assign w_cur_push   = (w_in_fire && (w_dir == SEL_CUR)) || w_start_fire;
  assign w_nxt_push   = w_in_fire && (w_dir == SEL_NXT);
  assign w_cur_wdata  = (bus.in_pc_valid && (w_dir == SEL_CUR)) ? bus.in_pc : bus.start_pc;
  assign w_adv_ok     = bus.advance && !w_out_vld && !bus.in_pc_valid && !bus.start_valid;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_is_cur[b] = (r_cur_sel == 1'(b));
    assign w_push[b]   = w_is_cur[b] ? w_cur_push : w_nxt_push;
    assign w_pop_b[b]  = w_is_cur[b] && w_pop;
    assign w_wdata[b]  = w_is_cur[b] ? w_cur_wdata : bus.in_pc;

    pc_bank_fifo #(
      .PC_WIDTH   (PC_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[b]),
      .i_data  (w_wdata[b]),
      .i_pop   (w_pop_b[b]),
      .o_head  (w_head[b]),
      .o_count (w_count[b]),
      .o_full  (w_full[b]),
      .o_empty (w_empty[b]),
      .o_ovf   (w_ovf[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_sel  <= 1'b0;
      r_adv_done <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_adv_ok) r_cur_sel <= ~r_cur_sel;
      r_adv_done <= w_adv_ok;
      r_ovf      <= r_ovf | (|w_ovf);
    end
  end

  assign bus.out_pc_valid = w_out_vld;
  assign bus.out_pc       = w_out_vld ? w_head[r_cur_sel] : '0;
  assign bus.in_pc_ready  = w_in_rdy;
  assign bus.start_ready  = w_start_rdy;
  assign bus.advance_done = r_adv_done;
  assign bus.cur_empty    = w_empty[r_cur_sel];
  assign bus.nxt_empty    = w_empty[~r_cur_sel];
  assign bus.overflow     = r_ovf;

`ifdef PC_DISPATCH_OCCUPANCY_EN
  logic [DEPTH_LOG2:0] r_hwm, w_hwm_nxt;

  always_comb begin
    w_hwm_nxt = r_hwm;
    if (w_count[0] > w_hwm_nxt) w_hwm_nxt = w_count[0];
    if (w_count[1] > w_hwm_nxt) w_hwm_nxt = w_count[1];
  end

  always_ff @(posedge clk) begin
    if (reset) r_hwm <= '0;
    else       r_hwm <= w_hwm_nxt;
  end

  assign bus.cur_count      = w_cur_count;
  assign bus.nxt_count      = w_count[~r_cur_sel];
  assign bus.high_watermark = r_hwm;
`endif
endmodule

// File: tb/tb_pc_dispatch_fifo.sv
// Randomized bench for pc_dispatch_fifo against a two-queue reference model.
module tb_pc_dispatch_fifo;
  localparam int PCW  = 8;
  localparam int DL2  = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_dispatch_fifo_if #(.PC_WIDTH(PCW), .DEPTH_LOG2(DL2)) bus ();

  pc_dispatch_fifo #(.PC_WIDTH(PCW), .DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the two banks as plain queues, roles swapped by swapping contents.
  bit [7:0] cq[$];
  bit [7:0] nq[$];
  bit       exp_adv;
  int       hwm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.start_valid = 1'b0; bus.start_pc = '0;
    bus.in_pc_valid = 1'b0; bus.in_pc = '0; bus.in_pc_is_directed_to_current = 1'b0;
    bus.out_pc_ready = 1'b0; bus.advance = 1'b0;
  endtask

  task automatic model_clear();
    cq.delete(); nq.delete(); exp_adv = 1'b0; hwm = 0;
  endtask

  // One clock cycle: apply inputs, compare outputs with the model, then advance the model.
  task automatic drive(input bit sv, input bit [7:0] spc, input bit iv, input bit [7:0] ipc,
                       input bit idir, input bit ordy, input bit adv);
    bit cfull, nfull, pop, irdy, srdy, advok;
    bit [7:0] tmp[$];
    @(negedge clk);
    bus.start_valid = sv; bus.start_pc = spc;
    bus.in_pc_valid = iv; bus.in_pc = ipc; bus.in_pc_is_directed_to_current = idir;
    bus.out_pc_ready = ordy; bus.advance = adv;
    #1;
    cfull = (cq.size() == DEPTH);
    nfull = (nq.size() == DEPTH);
    pop   = (cq.size() != 0) && ordy;
    irdy  = !iv || (idir ? (!cfull || pop) : !nfull);
    srdy  = !cfull && !(iv && idir);
    chk("out_pc_valid", bus.out_pc_valid, cq.size() != 0);
    chk("out_pc", bus.out_pc, (cq.size() != 0) ? cq[0] : 8'h00);
    chk("in_pc_ready", bus.in_pc_ready, irdy);
    chk("start_ready", bus.start_ready, srdy);
    chk("cur_empty", bus.cur_empty, cq.size() == 0);
    chk("nxt_empty", bus.nxt_empty, nq.size() == 0);
    chk("advance_done", bus.advance_done, exp_adv);
    chk("overflow", bus.overflow, 1'b0);
`ifdef PC_DISPATCH_OCCUPANCY_EN
    chk("cur_count", bus.cur_count, cq.size());
    chk("nxt_count", bus.nxt_count, nq.size());
    chk("high_watermark", bus.high_watermark, hwm);
`endif
    @(posedge clk);
    if (cq.size() > hwm) hwm = cq.size();
    if (nq.size() > hwm) hwm = nq.size();
    advok = adv && (cq.size() == 0) && !iv && !sv;
    if (pop) void'(cq.pop_front());
    if (iv && irdy) begin
      if (idir) cq.push_back(ipc);
      else      nq.push_back(ipc);
    end
    if (sv && srdy) cq.push_back(spc);
    if (advok) begin
      tmp = cq; cq = nq; nq = tmp;
    end
    exp_adv = advok;
    #1;
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_out_pc_valid", bus.out_pc_valid, 1'b0);
    chk("rst_out_pc", bus.out_pc, 8'h00);
    chk("rst_in_pc_ready", bus.in_pc_ready, 1'b1);
    chk("rst_start_ready", bus.start_ready, 1'b1);
    chk("rst_advance_done", bus.advance_done, 1'b0);
    chk("rst_cur_empty", bus.cur_empty, 1'b1);
    chk("rst_nxt_empty", bus.nxt_empty, 1'b1);
    chk("rst_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Start then pop.
    drive(1, 8'hCC, 0, 0, 0, 0, 0);
    chk("start_vld", bus.out_pc_valid, 1'b1);
    chk("start_pc", bus.out_pc, 8'hCC);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("start_drained", bus.cur_empty, 1'b1);

    // Routing and advance.
    drive(0, 0, 1, 8'h0F, 1, 0, 0);
    drive(0, 0, 1, 8'h10, 0, 0, 0);
    chk("route_cur", bus.out_pc, 8'h0F);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("route_adv_done", bus.advance_done, 1'b1);
    chk("route_nxt", bus.out_pc, 8'h10);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Fill nxt bank, probe readiness on both targets.
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 8'(8'h40 + i), 0, 0, 0);
    drive(0, 0, 1, 8'hEE, 0, 0, 0);
    drive(0, 0, 1, 8'h55, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 8'h66, 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, 0);

    // Full cur bank with simultaneous push+pop across pointer wrap.
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h80 + i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 8'($urandom), 1, 1, 0);
`ifdef PC_DISPATCH_OCCUPANCY_EN
    chk("mixed_count", bus.cur_count, DEPTH);
`endif
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, 0);

    // Refused advances, then a successful retry.
    drive(1, 8'h21, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("adv_refused_cnt", bus.advance_done, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 8'h22, 0, 0, 1);
    chk("adv_refused_in", bus.advance_done, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("adv_retry", bus.advance_done, 1'b1);
    chk("adv_retry_pc", bus.out_pc, 8'h22);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) drive(1, 8'(8'hA0 + i), 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 8'hCD, 0, 0, 0, 0, 0);
    chk("post_rst_pc", bus.out_pc, 8'hCD);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 4) == 0, 8'($urandom),
            $urandom_range(0, 9) < 6, 8'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 5, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
